// File: rtl/avalon_mm_pkg.sv
// Shared types and default sizes for the Avalon-MM master block.
// The optional watchdog is controlled by the AVM_TIMEOUT_EN macro in the top file.
package avalon_mm_pkg;

  localparam int AVM_ADDR_W      = 32;
  localparam int AVM_DATA_W      = 32;
  localparam int AVM_TIMEOUT_CYC = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_REQ  = 2'd1,
    RD_REQ  = 2'd2,
    RD_WAIT = 2'd3
  } avm_state_e;

endpackage

// File: rtl/avalon_master_mm_interface.sv
// Avalon-MM master: one local command in flight, one response per command.
// Define AVM_TIMEOUT_EN to add a watchdog that aborts a stuck transfer with rsp_error.
module avalon_master_mm_interface
  import avalon_mm_pkg::*;
#(
  parameter int ADDR_W      = AVM_ADDR_W,
  parameter int DATA_W      = AVM_DATA_W,
  parameter int TIMEOUT_CYC = AVM_TIMEOUT_CYC
) (
  input  logic                clock,
  input  logic                reset,
  // Local command/response side
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_address,
  input  logic [DATA_W-1:0]   cmd_writedata,
  input  logic [DATA_W/8-1:0] cmd_byteenable,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_error,
  // Avalon-MM side
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata,
  input  logic                readdatavalid
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both 1; rsp_valid is a single-cycle pulse with no back-pressure.

  avm_state_e state;
  logic       wd_abort;

`ifdef AVM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  // A normal completion on the same edge wins over the watchdog.
  assign wd_abort   = wd_expired && (state != IDLE)
                      && !(state == WR_REQ && !waitrequest)
                      && !(state == RD_WAIT && readdatavalid);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt    <= '0;
      rsp_error <= 1'b0;
    end else begin
      wd_cnt    <= (state == IDLE) ? '0 : wd_cnt + WD_W'(1);
      rsp_error <= wd_abort;
    end
  end
`else
  assign wd_abort  = 1'b0;
  assign rsp_error = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            address    <= cmd_address;
            writedata  <= cmd_writedata;
            byteenable <= cmd_byteenable;
            if (cmd_write) begin
              write <= 1'b1;
              state <= WR_REQ;
            end else begin
              read  <= 1'b1;
              state <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (!waitrequest) begin
            write     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        RD_REQ: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (readdatavalid) begin
            rsp_data  <= readdata;
            rsp_valid <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (wd_abort) begin
        read      <= 1'b0;
        write     <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_data  <= '0;
        cmd_ready <= 1'b1;
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_avalon_master_mm_interface.sv
// Bench for avalon_master_mm_interface: directed cases plus random traffic against a word memory model.
// The slave model stalls and delays reads at random; responses are scored from a reference memory.
module tb_avalon_master_mm_interface;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int TO_CYC = 8;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } bus_t;

  logic              clock;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_writedata;
  logic [BE_W-1:0]   cmd_byteenable;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_error;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  avalon_master_mm_interface #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .cmd_byteenable(cmd_byteenable),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .readdatavalid(readdatavalid)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W:0]   exp_q[$];   // {rsp_error, rsp_data}
  bus_t              bus_q[$];
  logic [DATA_W-1:0] ref_mem[16];
  logic [DATA_W-1:0] slv_mem[16];
  logic [DATA_W-1:0] last_rsp = '0;
  logic              prev_rsp = 1'b0;
  logic              acc_with_rsp = 1'b0;

  int stall_sel  = -1;
  int lat_sel    = -1;
  bit spur_en    = 1'b0;
  bit spur_force = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                               input logic [DATA_W-1:0] new_v,
                                               input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  // ---------------- response monitor ----------------
  always @(negedge clock) begin
    logic [DATA_W:0] e;
    if (reset) begin
      check("rd_wr_excl", {63'b0, read & write}, 64'd0);
      if (rsp_valid) begin
        check("rsp_consec", {63'b0, prev_rsp}, 64'd0);
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp", {31'b0, rsp_error, rsp_data}, {31'b0, e});
          last_rsp = e[DATA_W-1:0];
        end
      end else begin
        check("rsp_hold", {32'b0, rsp_data}, {32'b0, last_rsp});
      end
      prev_rsp = rsp_valid;
    end else begin
      prev_rsp = 1'b0;
    end
  end

  // ---------------- slave model ----------------
  initial begin
    bus_t cur;
    bit   in_xfer;
    int   stall_left;
    int   rd_cnt;
    logic [DATA_W-1:0] rd_val;
    in_xfer = 0; stall_left = 0; rd_cnt = 0; rd_val = '0; cur = '0;
    waitrequest = 1'b0; readdatavalid = 1'b0; readdata = '0;
    forever begin
      @(negedge clock);
      readdatavalid = 1'b0;
      readdata      = $urandom;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          readdatavalid = 1'b1;
          readdata      = rd_val;
        end
      end else if (!read && (spur_force || (spur_en && $urandom_range(0, 7) == 0))) begin
        readdatavalid = 1'b1;
        readdata      = '1;
      end
      if (read || write) begin
        if (!in_xfer) begin
          in_xfer = 1;
          if (bus_q.size() == 0) begin
            check("bus_unexpected", 64'd1, 64'd0);
            cur = '0;
          end else begin
            cur = bus_q.pop_front();
          end
          stall_left = (stall_sel < 0) ? $urandom_range(0, 2) : stall_sel;
        end
        check("bus_kind", {63'b0, write}, {63'b0, cur.wr});
        check("bus_addr", {32'b0, address}, {32'b0, cur.addr});
        check("bus_be", {60'b0, byteenable}, {60'b0, cur.be});
        if (write) check("bus_wdata", {32'b0, writedata}, {32'b0, cur.data});
        if (stall_left > 0) begin
          waitrequest = 1'b1;
          stall_left--;
        end else begin
          waitrequest = 1'b0;
          in_xfer     = 0;
          if (write) slv_mem[address[5:2]] = merge(slv_mem[address[5:2]], writedata, byteenable);
          else begin
            rd_val = slv_mem[address[5:2]];
            rd_cnt = (lat_sel < 0) ? $urandom_range(1, 2) : lat_sel;
          end
        end
      end else begin
        in_xfer     = 0;
        waitrequest = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit wr, input logic [3:0] idx, input logic [DATA_W-1:0] d,
                      input logic [BE_W-1:0] be, input bit hold);
    int n;
    bus_t t;
    @(negedge clock);
    cmd_valid      = 1'b1;
    cmd_write      = wr;
    cmd_address    = {26'b0, idx, 2'b00};
    cmd_writedata  = d;
    cmd_byteenable = be;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("cmd_accept", {63'b0, cmd_ready}, 64'd1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    acc_with_rsp = rsp_valid;
    t.wr = wr; t.addr = cmd_address; t.data = d; t.be = be;
    bus_q.push_back(t);
    if (wr) begin
      ref_mem[idx] = merge(ref_mem[idx], d, be);
      exp_q.push_back({1'b0, {DATA_W{1'b0}}});
    end else begin
      exp_q.push_back({1'b0, ref_mem[idx]});
    end
    @(posedge clock);
    if (!hold) begin
      #1;
      cmd_valid     = 1'b0;
      cmd_write     = 1'($urandom_range(0, 1));
      cmd_address   = $urandom;
      cmd_writedata = $urandom;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("idle_reached", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clock);
  endtask

  task automatic count_read_cycles(output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (read) cnt++;
      else if (cnt > 0) break;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    int r;
    bit seen;
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
    cmd_writedata = '0; cmd_byteenable = '0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end

    repeat (3) @(negedge clock);
    check("rst_cmd_ready", {63'b0, cmd_ready}, 64'd0);
    check("rst_strobes", {62'b0, read, write}, 64'd0);
    check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check("rst_rsp_error", {63'b0, rsp_error}, 64'd0);
    check("rst_rsp_data", {32'b0, rsp_data}, 64'd0);
    check("rst_address", {32'b0, address}, 64'd0);
    reset = 1'b1;
    #1 check("cmd_ready_before_edge", {63'b0, cmd_ready}, 64'd0);
    @(negedge clock);
    check("cmd_ready_after_edge", {63'b0, cmd_ready}, 64'd1);

    // write with no stall
    stall_sel = 0; lat_sel = 1;
    send(1'b1, 4'd1, 32'hCAFE0001, 4'hF, 1'b0);
    @(negedge clock);
    check("wr_strobe", {63'b0, write}, 64'd1);
    check("wr_address", {32'b0, address}, 64'h4);
    check("wr_data", {32'b0, writedata}, 64'hCAFE0001);
    @(negedge clock);
    check("wr_done", {62'b0, write, rsp_valid}, 64'd1);
    check("wr_rsp_data", {32'b0, rsp_data}, 64'd0);
    wait_idle();

    // read with 3 stall cycles
    send(1'b1, 4'd2, 32'h12345678, 4'hF, 1'b0);
    wait_idle();
    stall_sel = 3;
    send(1'b0, 4'd2, 32'h0, 4'hF, 1'b0);
    count_read_cycles(cnt);
    check("rd_strobe_len", 64'(cnt), 64'd4);
    wait_idle();
    check("rd_data", {32'b0, rsp_data}, 64'h12345678);

    // back-to-back write then read, cmd_valid held
    stall_sel = 0;
    send(1'b1, 4'd0, 32'hA5A5A5A5, 4'hF, 1'b1);
    send(1'b0, 4'd0, 32'h0, 4'hF, 1'b0);
    check("b2b_accept_in_rsp", {63'b0, acc_with_rsp}, 64'd1);
    wait_idle();
    check("b2b_rd_data", {32'b0, rsp_data}, 64'hA5A5A5A5);

    // spurious readdatavalid while idle
    spur_force = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("spur_no_rsp", {63'b0, rsp_valid}, 64'd0);
    end
    spur_force = 1'b0;
    check("spur_hold", {32'b0, rsp_data}, 64'hA5A5A5A5);

    // random traffic
    stall_sel = -1; lat_sel = -1; spur_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      bit hold;
      hold = 1'($urandom_range(0, 1));
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
           4'($urandom_range(0, 15)), hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    wait_idle();
    spur_en = 1'b0;

    // reset while waiting for read data
    stall_sel = 0; lat_sel = 4;
    send(1'b0, 4'd5, 32'h0, 4'hF, 1'b0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (read) seen = 1;
      else if (seen) break;
    end
    #2 reset = 1'b0;
    #1;
    check("mid_rst_read", {63'b0, read}, 64'd0);
    check("mid_rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check("mid_rst_cmd_ready", {63'b0, cmd_ready}, 64'd0);
    exp_q.delete();
    bus_q.delete();
    last_rsp = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    r = 0;
    repeat (8) begin
      @(negedge clock);
      r += int'(rsp_valid);
    end
    check("post_rst_no_rsp", 64'(r), 64'd0);
    lat_sel = 1;
    send(1'b1, 4'd5, 32'h0BADF00D, 4'hF, 1'b0);
    send(1'b0, 4'd5, 32'h0, 4'hF, 1'b0);
    wait_idle();
    check("post_rst_rd", {32'b0, rsp_data}, 64'h0BADF00D);

`ifdef AVM_TIMEOUT_EN
    stall_sel = 100;
    send(1'b0, 4'd3, 32'h0, 4'hF, 1'b0);
    void'(exp_q.pop_back());
    exp_q.push_back({1'b1, {DATA_W{1'b0}}});
    count_read_cycles(cnt);
    check("to_strobe_len", 64'(cnt), 64'(TO_CYC));
    wait_idle();
    check("to_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    stall_sel = 0;
`endif

    check("final_exp_empty", 64'(exp_q.size()), 64'd0);
    check("final_bus_empty", 64'(bus_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
